dct_8x8_fwd: RTL and testbench



---
 rtl/dct_8x8_fwd.sv | 190 +++++++++++++++++++
 tb/tb_dct_8x8_fwd.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_8x8_fwd.sv
// dct_8x8_fwd: forward 8x8 DCT-II, row then column pass on one shared MAC.
// Define DCT_LEVEL_SHIFT_EN to subtract 128 from every pixel before the transform.
module dct_8x8_fwd (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [7:0]         pixel_in [0:7][0:7],
  output logic               busy,
  output logic               done,
  output logic signed [11:0] coef_out [0:7][0:7]
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_COL,
    S_DONE
  } state_t;

  // COS[n][k] = round(16384 * cos((2n+1)k*pi/16))
  localparam logic signed [15:0] COS [0:7][0:7] = '{
    '{16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
      16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196},
    '{16'sd16384,  16'sd13623,  16'sd6270,  -16'sd3196,
     -16'sd11585, -16'sd16069, -16'sd15137, -16'sd9102},
    '{16'sd16384,  16'sd9102,  -16'sd6270,  -16'sd16069,
     -16'sd11585,  16'sd3196,   16'sd15137,  16'sd13623},
    '{16'sd16384,  16'sd3196,  -16'sd15137, -16'sd9102,
      16'sd11585,  16'sd13623, -16'sd6270,  -16'sd16069},
    '{16'sd16384, -16'sd3196,  -16'sd15137,  16'sd9102,
      16'sd11585, -16'sd13623, -16'sd6270,   16'sd16069},
    '{16'sd16384, -16'sd9102,  -16'sd6270,   16'sd16069,
     -16'sd11585, -16'sd3196,   16'sd15137, -16'sd13623},
    '{16'sd16384, -16'sd13623,  16'sd6270,   16'sd3196,
     -16'sd11585,  16'sd16069, -16'sd15137,  16'sd9102},
    '{16'sd16384, -16'sd16069,  16'sd15137, -16'sd13623,
      16'sd11585, -16'sd9102,   16'sd6270,  -16'sd3196}
  };

  state_t r_state;
  state_t w_next;

  logic [3:0]         r_step;
  logic [2:0]         r_u;
  logic [2:0]         r_o;
  logic signed [39:0] r_acc;
  logic [7:0]         r_p [0:7][0:7];
  logic signed [15:0] r_t [0:7][0:7];
  logic signed [11:0] r_c [0:7][0:7];

  logic               w_row;
  logic               w_store;
  logic               w_last;
  logic [2:0]         w_n;
  logic [7:0]         w_pix;
  logic signed [8:0]  w_s;
  logic signed [15:0] w_tv;
  logic signed [15:0] w_cos16;
  logic signed [39:0] w_a;
  logic signed [39:0] w_c;
  logic signed [39:0] w_prod;
  logic signed [63:0] w_acc64;
  logic signed [63:0] w_scale;
  logic signed [63:0] w_rnd;
  logic signed [63:0] w_shift;
  logic signed [11:0] w_sat;

  assign w_row   = (r_state == S_ROW);
  assign w_store = (r_step == 4'd8);
  assign w_last  = w_store && (&r_u) && (&r_o);
  assign w_n     = r_step[2:0];

  assign w_pix = r_p[r_o][w_n];
`ifdef DCT_LEVEL_SHIFT_EN
  assign w_s = $signed({1'b0, w_pix}) - 9'sd128;
`else
  assign w_s = $signed({1'b0, w_pix});
`endif
  assign w_tv    = r_t[w_n][r_o];
  assign w_cos16 = COS[w_n][r_u];

  assign w_a = w_row ? {{31{w_s[8]}}, w_s}
                     : {{24{w_tv[15]}}, w_tv};
  assign w_c    = {{24{w_cos16[15]}}, w_cos16};
  assign w_prod = w_a * w_c;

  // Row results keep 3 fraction bits; column results are integers
  assign w_acc64 = {{24{r_acc[39]}}, r_acc};
  assign w_scale = (r_u == 3'd0) ? 64'sd11585 : 64'sd16384;
  assign w_rnd   = w_acc64 * w_scale
                 + (w_row ? 64'sd33554432 : 64'sd2147483648);
  assign w_shift = w_row ? (w_rnd >>> 26) : (w_rnd >>> 32);

  always_comb begin
    w_sat = w_shift[11:0];
    if (w_shift > 64'sd2047)
      w_sat = 12'sh7ff;
    else if (w_shift < -64'sd2048)
      w_sat = 12'sh800;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_ROW;
      end
      S_ROW: begin
        busy = 1'b1;
        if (w_last) w_next = S_COL;
      end
      S_COL: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_acc  <= '0;
      r_step <= '0;
      r_u    <= '0;
      r_o    <= '0;
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          r_p[i][j]      <= '0;
          r_t[i][j]      <= '0;
          r_c[i][j]      <= '0;
          coef_out[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          r_p    <= pixel_in;
          r_acc  <= '0;
          r_step <= '0;
          r_u    <= '0;
          r_o    <= '0;
        end
        S_ROW, S_COL: begin
          if (!w_store) begin
            r_acc  <= r_acc + w_prod;
            r_step <= r_step + 4'd1;
          end else begin
            r_acc  <= '0;
            r_step <= '0;
            r_u    <= r_u + 3'd1;
            if (&r_u)
              r_o <= r_o + 3'd1;
            if (w_row) begin
              r_t[r_o][r_u] <= w_shift[15:0];
            end else begin
              r_c[r_u][r_o] <= w_sat;
              // Publish the whole block at once, including the last store
              if (w_last) begin
                for (int i = 0; i < 8; i++) begin
                  for (int j = 0; j < 8; j++) begin
                    coef_out[i][j] <= (i == 7 && j == 7)
                                      ? w_sat : r_c[i][j];
                  end
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_8x8_fwd.sv
// tb_dct_8x8_fwd: vector table, corner sequences and random blocks
// checked against an array-based fixed-point DCT reference.
module tb_dct_8x8_fwd;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               start;
  logic [7:0]         pixel_in [0:7][0:7];
  logic               busy;
  logic               done;
  logic signed [11:0] coef_out [0:7][0:7];

  dct_8x8_fwd dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .pixel_in (pixel_in),
    .busy     (busy),
    .done     (done),
    .coef_out (coef_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int fill;
    int exp_dc;
  } vec_t;

  vec_t vt [0:2];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   g_pix [0:7][0:7];
  int   g_ref [0:7][0:7];
  int   cq    [0:7][0:7];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_near(input string nm, input longint act,
                            input longint exp, input longint tol);
    n_chk++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d +/- %0d",
               nm, act, exp, tol);
    end
  endtask

  task automatic build_cos();
    real a;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) begin
        a = 16384.0 * $cos(real'((2 * n + 1) * k)
                           * 3.14159265358979 / 16.0);
        cq[n][k] = $rtoi($floor(a + 0.5));
      end
    end
  endtask

  function automatic longint scl(input int k);
    return (k == 0) ? 64'sd11585 : 64'sd16384;
  endfunction

  task automatic model();
    int     s [0:7][0:7];
    int     t [0:7][0:7];
    longint acc;
    longint q;
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 8; n++) begin
`ifdef DCT_LEVEL_SHIFT_EN
        s[r][n] = g_pix[r][n] - 128;
`else
        s[r][n] = g_pix[r][n];
`endif
      end
    end
    for (int r = 0; r < 8; r++) begin
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int n = 0; n < 8; n++)
          acc += longint'(s[r][n]) * longint'(cq[n][u]);
        q = (acc * scl(u) + (longint'(1) << 25)) >>> 26;
        t[r][u] = int'(shortint'(q));
      end
    end
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int n = 0; n < 8; n++)
          acc += longint'(t[n][v]) * longint'(cq[n][u]);
        q = (acc * scl(u) + (longint'(1) << 31)) >>> 32;
        if (q > 2047)
          g_ref[u][v] = 2047;
        else if (q < -2048)
          g_ref[u][v] = -2048;
        else
          g_ref[u][v] = int'(q);
      end
    end
  endtask

  task automatic set_pixels();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        pixel_in[r][c] = 8'(g_pix[r][c]);
  endtask

  task automatic scramble();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        pixel_in[r][c] = 8'($urandom);
  endtask

  task automatic fill_pix(input int val);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        g_pix[r][c] = val;
  endtask

  task automatic rand_pix();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        g_pix[r][c] = $urandom_range(0, 255);
  endtask

  function automatic int nonzero_all();
    int cnt = 0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if (coef_out[u][v] != 0) cnt++;
    return cnt;
  endfunction

  function automatic int nonzero_ac();
    int cnt = 0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if ((u != 0 || v != 0) && coef_out[u][v] != 0) cnt++;
    return cnt;
  endfunction

  task automatic compare_block(input string nm);
    model();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        check($sformatf("%s_c%0d%0d", nm, u, v),
              coef_out[u][v], g_ref[u][v]);
  endtask

  task automatic run_block(input string nm, input bit scram);
    int cnt;
    set_pixels();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_busy"}, busy, 1);
    tick();
    if (scram) scramble();
    cnt = 1;
    while (!done && cnt < 1200) begin
      tick();
      cnt++;
    end
    check({nm, "_lat"}, cnt, 1153);
    compare_block(nm);
    tick();
    check({nm, "_done_low"}, done, 0);
    check({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int cnt;
    int pulses;
    int lat;

    build_cos();
`ifdef DCT_LEVEL_SHIFT_EN
    vt[0] = '{128, 0};
    vt[1] = '{255, 1016};
    vt[2] = '{0, -1024};
`else
    vt[0] = '{128, 1024};
    vt[1] = '{255, 2040};
    vt[2] = '{0, 0};
`endif

    sys_rst = 1'b1;
    start   = 1'b0;
    fill_pix(0);
    set_pixels();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coef_nz", nonzero_all(), 0);

    start = 1'b1;
    tick();
    check("rst_wins_busy", busy, 0);
    sys_rst = 1'b0;
    start   = 1'b0;
    tick();
    check("rst_wins_idle", busy, 0);

    for (int i = 0; i < 3; i++) begin
      fill_pix(vt[i].fill);
      run_block($sformatf("flat%0d", vt[i].fill), 1'b1);
      check($sformatf("flat%0d_dc", vt[i].fill),
            coef_out[0][0], vt[i].exp_dc);
      check($sformatf("flat%0d_ac_nz", vt[i].fill), nonzero_ac(), 0);
    end

    fill_pix(128);
    g_pix[0][0] = 255;
    run_block("imp", 1'b1);
`ifdef DCT_LEVEL_SHIFT_EN
    check("imp_c00", coef_out[0][0], 16);
`else
    check_near("imp_c00", coef_out[0][0], 1040, 1);
`endif
    check_near("imp_c01", coef_out[0][1], 22, 1);
    check_near("imp_c10", coef_out[1][0], 22, 1);

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        g_pix[r][c] = 16 * c;
    set_pixels();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cnt    = 1;
    pulses = 0;
    lat    = -1;
    while (cnt < 1300) begin
      start = (cnt >= 100 && cnt < 104);
      tick();
      cnt++;
      if (done) begin
        pulses++;
        if (lat < 0) lat = cnt;
      end
    end
    start = 1'b0;
    check("ramp_pulses", pulses, 1);
    check("ramp_lat", lat, 1153);
    check("ramp_idle", busy, 0);
    compare_block("ramp");
    cnt = 0;
    for (int u = 1; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if (coef_out[u][v] != 0) cnt++;
    check("ramp_rows_nz", cnt, 0);
    check("ramp_c01_neg", coef_out[0][1] < 0, 1);

    check("mid_pre_nz", nonzero_all() != 0, 1);
    rand_pix();
    set_pixels();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 599; k++) tick();
    check("mid_busy_pre", busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_coef_nz", nonzero_all(), 0);
    pulses = 0;
    for (int k = 0; k < 1300; k++) begin
      tick();
      if (done) pulses++;
    end
    check("mid_no_done", pulses, 0);
    check("mid_idle", busy, 0);

    for (int k = 0; k < 4; k++) begin
      rand_pix();
      run_block($sformatf("rnd%0d", k), 1'b1);
    end

    rand_pix();
    set_pixels();
    start = 1'b1;
    tick();
    cnt = 0;
    while (!done && cnt < 1200) begin
      tick();
      cnt++;
    end
    check("b2b_lat0", cnt, 1153);
    compare_block("b2b0");
    tick();
    tick();
    check("b2b_restart", busy, 1);
    start = 1'b0;
    cnt = 2;
    while (!done && cnt < 1300) begin
      tick();
      cnt++;
    end
    check("b2b_period", cnt, 1155);
    compare_block("b2b1");
    tick();
    check("b2b_done_low", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
